// File: rtl/load_store_unit.sv
// load_store_unit
//   Sole master of a word-wide synchronous data memory. Accepts byte, half and
//   word load/store requests over a valid/ready handshake and turns each one
//   into word memory cycles. Sub-word stores use read-modify-write. Loads
//   return sign- or zero-extended data over a held valid/ready response.
//
// Ports
//   clk, rst_n            clock (shared with memory), async active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_size      1 = store; size 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata   byte address, right-justified store data
//   resp_valid/ready      response handshake, valid held until accepted
//   resp_rdata, resp_err  extended load data (0 for stores/errors), reject flag
//   mem_addr, mem_wdata   word address and write data to memory
//   mem_we, mem_rdata     write strobe (low = read), registered read data
//
// Configuration
//   MISALIGN_TRAP_EN  when defined, misaligned half/word requests are rejected
//                     with resp_err and make no memory access. When undefined,
//                     the unused low address bits are ignored.
module load_store_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        off_q, off_d;       // byte offset within the word
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [15:0]       wdata_q, wdata_d;   // only sub-word stores need it later
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              misalign_s;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        uns);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   res = {{24{byte_v[7] & ~uns}}, byte_v};
            2'b01:   res = {{16{half_v[15] & ~uns}}, half_v};
            default: res = word;
        endcase
        return res;
    endfunction

    // Overlay sub-word store data onto the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] res;
        res = word;
        case (size)
            2'b00:   res[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   res[{off[1], 4'b0000} +: 16] = wdata;
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef MISALIGN_TRAP_EN
    assign misalign_s = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    we_d    = req_we;
                    wdata_d = req_wdata[15:0];
                    if ((req_size == 2'b11) || misalign_s) begin
                        // Rejected: straight to the response, memory untouched.
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_we && (req_size == 2'b10)) begin
                        // Full-word store needs no read-back.
                        state_d     = S_WRITE;
                        mem_addr_d  = req_addr[ADDR_W+1:2];
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        mem_addr_d = req_addr[ADDR_W+1:2];
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (we_q) begin
                    mem_wdata_d = store_merge(mem_rdata, wdata_q, size_q, off_q);
                    mem_we_d    = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    resp_rdata_d = load_extend(mem_rdata, size_q, off_q, uns_q);
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'd0;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
        // Registered ready mirrors the state being entered.
        req_ready_d = (state_d == S_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 16'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a behavioural memory, a reference model of
// the load/store rules, a scoreboard queue filled at request time and a
// monitor that checks every response as it is accepted.
module tb_load_store_unit;
    localparam int AW = 7;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_we;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    logic [31:0]   dmem  [0:NW-1];
    logic [31:0]   model [0:NW-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = 32'd0;
    int            wr_cnt = 0;
    int            cyc = 0;
    logic [AW-1:0] last_waddr = '0;

    // Data memory: registered read, write on strobe, preload port for setup.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (mem_we) begin
            dmem[mem_addr] <= mem_wdata;
            wr_cnt         <= wr_cnt + 1;
            last_waddr     <= mem_addr;
        end
        mem_rdata <= dmem[mem_addr];
    end

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            writes;
        logic [AW-1:0] waddr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   outstanding = 0;
    int   hs_cyc = 0;
    int   wr_base = 0;
    int   hold_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Consumer: holds resp_ready low for hold_n cycles, then accepts randomly.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!resp_valid) begin
                wait_cnt = 0;
                resp_ready = 1'($urandom_range(0, 1));
            end else begin
                resp_ready = (wait_cnt >= hold_n) && ($urandom_range(0, 3) != 0);
                wait_cnt++;
            end
        end
    end

    // Monitor: latency, stability while stalled, and final values on accept.
    initial begin
        bit          seen;
        logic [31:0] held_rdata;
        logic        held_err;
        exp_t        e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                chk("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                if (!seen) begin
                    seen = 1'b1;
                    held_rdata = resp_rdata;
                    held_err = resp_err;
                    chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) chk("latency", cyc - hs_cyc + 1, sb[0].lat);
                end else begin
                    chk("stable_rdata", resp_rdata, held_rdata);
                    chk("stable_err", {31'd0, resp_err}, {31'd0, held_err});
                end
                if (resp_ready) begin
                    seen = 1'b0;
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                        chk("write_count", wr_cnt - wr_base, e.writes);
                        if (e.writes == 1) chk("write_addr", {25'd0, last_waddr}, {25'd0, e.waddr});
                        outstanding--;
                    end
                end
            end
        end
    end

    // Issue one request; the expected response is derived from the rules.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wdata, input int hold);
        exp_t        e;
        logic [31:0] w, v, mask;
        int          idx, bo, sh;
        bit          got;
        idx = int'(addr[AW+1:2]);
        bo  = int'(addr[1:0]);
        w   = model[idx];
        e.err = (size == 2'b11);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'b01 && (bo % 2) != 0) e.err = 1'b1;
        if (size == 2'b10 && bo != 0) e.err = 1'b1;
`endif
        e.rdata = 32'd0;
        e.writes = 0;
        e.waddr = addr[AW+1:2];
        if (e.err) e.lat = 1;
        else if (we) begin
            if (size == 2'b00) begin
                sh = 8 * bo;
                mask = 32'hFF << sh;
                v = (w & ~mask) | ((wdata & 32'hFF) << sh);
                e.lat = 4;
            end else if (size == 2'b01) begin
                sh = 16 * (bo / 2);
                mask = 32'hFFFF << sh;
                v = (w & ~mask) | ((wdata & 32'hFFFF) << sh);
                e.lat = 4;
            end else begin
                v = wdata;
                e.lat = 2;
            end
            e.writes = 1;
            model[idx] = v;
        end else begin
            if (size == 2'b00) begin
                v = (w >> (8 * bo)) & 32'hFF;
                if (!uns && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2'b01) begin
                v = (w >> (16 * (bo / 2))) & 32'hFFFF;
                if (!uns && v >= 32'd32768) v = v - 32'd65536;
            end else v = w;
            e.rdata = v;
            e.lat = 3;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; hold_n = hold;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            timeout_fail("req_accept");
            req_valid = 1'b0;
        end else begin
            chk("no_overlap", outstanding, 32'd0);
            sb.push_back(e);
            @(posedge clk);
            #1;
            hs_cyc = cyc;
            wr_base = wr_cnt;
            outstanding++;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (outstanding == 0 && req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("wait_idle");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nmis;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'd0;
        pre_we = 1'b1;
        for (int i = 0; i < NW; i++) begin
            pre_addr = AW'(i);
            pre_data = $urandom;
            model[i] = pre_data;
            @(negedge clk);
        end
        pre_we = 1'b0;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Directed cases.
        issue(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 0);
        issue(1'b1, 2'b10, 1'b0, 9'h010, 32'h80FF7F01, 1);
        issue(1'b0, 2'b00, 1'b0, 9'h013, 32'd0, 0);
        issue(1'b0, 2'b00, 1'b1, 9'h013, 32'd0, 0);
        issue(1'b1, 2'b10, 1'b0, 9'h010, 32'h11223344, 0);
        issue(1'b1, 2'b01, 1'b0, 9'h012, 32'h0000ABCD, 0);
        issue(1'b0, 2'b01, 1'b0, 9'h012, 32'd0, 0);
        wait_idle();
        issue(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, 5);
        issue(1'b0, 2'b11, 1'b0, 9'h004, 32'h12345678, 0);
        issue(1'b1, 2'b11, 1'b0, 9'h008, 32'h12345678, 0);
        issue(1'b0, 2'b10, 1'b0, 9'h011, 32'd0, 0);
        issue(1'b1, 2'b01, 1'b1, 9'h1FF, 32'h00005A5A, 0);
        issue(1'b0, 2'b10, 1'b1, 9'h1FC, 32'd0, 0);

        // Reset during the write cycle of a byte store.
        wait_idle();
        hold_n = 0;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 9'h021; req_wdata = ~model[8];
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (mem_we) break;
            @(posedge clk);
            #1;
        end
        chk("abort_write_reached", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop", {31'd0, mem_we}, 32'd0);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("abort_mem_unchanged", dmem[8], model[8]);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                  (AW+2)'($urandom), $urandom, $urandom_range(0, 2));
        end
        wait_idle();
        repeat (2) @(negedge clk);

        nmis = 0;
        for (int i = 0; i < NW; i++) if (dmem[i] !== model[i]) nmis++;
        chk("final_mem_mismatches", nmis, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory and is its only master.
- Accepts byte, halfword and word load/store requests from the CPU datapath over a valid/ready handshake.
- Translates each request into word-wide memory cycles, with read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data over a valid/ready response channel.

Parameters:
- ADDR_W, 7: word-address width of the data memory; the byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  rising-edge clock, shared with the data memory
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected, no memory access made
- mem_addr  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  word to write
- mem_we  out  1  write strobe; low = read cycle
- mem_rdata  in  32  word returned by memory, registered, valid the cycle after a read cycle

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - resp_valid, resp_err, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0.
  - A reset mid-operation aborts the transaction with no response.
  - mem_we drops immediately, so no write occurs at any edge while rst_n is low.
- All outputs come from registers. mem_we is 1 only in WRITE.
- States: IDLE, READ, DATA, WRITE, RESP.
- IDLE: req_ready=1. Handshake at edge E0 latches addr, size, unsigned, we and wdata. Next state:
  - size 11: RESP with err=1.
  - word store: WRITE, with mem_wdata=req_wdata.
  - all other requests: READ.
- READ: mem_addr=word address, mem_we=0. Next state DATA.
- DATA: mem_rdata is valid in this cycle.
  - Load: select the lane, extend it into resp_rdata, go to RESP.
  - Byte store: replace bits [8*a+7:8*a] with wdata[7:0], where a = addr[1:0].
  - Half store: replace bits [16*h+15:16*h] with wdata[15:0], where h = addr[1].
  - Stores register the merged word into mem_wdata and go to WRITE.
- WRITE: mem_we=1 for exactly one cycle. Next state RESP.
- RESP: resp_valid=1. When resp_ready=1, go to IDLE and clear resp_valid. resp_valid may not drop before acceptance. resp_ready=1 in the same cycle resp_valid rises completes the response in one cycle.
- Latency, counted as cycles after E0 in which resp_valid is first high:
  - error: 1
  - word store: 2
  - load: 3
  - byte/half store: 4
- Load lane selection:
  - Byte: lane addr[1:0], where lane 0 = bits [7:0].
  - Half: lane addr[1].
  - Word: the whole word; req_unsigned is ignored.
- req_unsigned is ignored for stores.
- Misalignment without the optional feature: low address bits beyond the access size are ignored (half ignores addr[0], word ignores addr[1:0]).
- A new request is never accepted while a transaction or response is pending; back-to-back transactions need RESP→IDLE.
- mem_addr does not wrap; the top word 2^ADDR_W−1 is legal.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1, or word with addr[1:0]≠0, goes IDLE→RESP.
  - resp_err=1, resp_rdata=0, no READ or WRITE cycle, and mem_we never asserts.
- MISALIGN_TRAP_EN undefined: the misalignment rule above applies; resp_err is raised only for size 11.

Test Plan:
- After reset, word store of 0xDEADBEEF to byte addr 0x010 → mem_we high for exactly 1 cycle with mem_addr=4; resp_valid in cycle 2, resp_err=0.
- Signed byte load, addr 0x013, with the word at 0x010 = 0x80FF7F01 → resp_rdata=0xFFFFFF80 in cycle 3. Same load with req_unsigned=1 → 0x00000080.
- Half store 0xABCD at addr 0x012 over 0x11223344 → read cycle, then written word 0xABCD3344; resp_valid in cycle 4. Signed half load from addr 0x012 → 0xFFFFABCD.
- resp_ready held low for 5 cycles → resp_valid and resp_rdata stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the handshake.
- req_size=11 → resp_err=1 in cycle 1, no mem_we. With MISALIGN_TRAP_EN, word load at addr 0x011 → resp_err=1; without it → data from word 4.
- rst_n pulsed low during WRITE of a byte store → mem_we drops immediately, memory unchanged, resp_valid=0, req_ready=1 after release.
